// File: rtl/ctrl_pipeline_pkg.sv
// rtl/ctrl_pipeline_pkg.sv - shared opcodes, select encodings and control bundle type
// Purpose: RV32I(+M) opcode constants, ALU operand-2 / op-class encodings and the
//          packed control bundle carried through the ID/EX stage register.
// Ports:   none (package)
package ctrl_pipeline_pkg;

   localparam logic [6:0] OPCODE_R      = 7'b0110011;
   localparam logic [6:0] OPCODE_IA     = 7'b0010011;
   localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
   localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
   localparam logic [6:0] OPCODE_B      = 7'b1100011;
   localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
   localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
   localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
   localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   localparam logic [1:0] ADD2_RS2 = 2'b00;
   localparam logic [1:0] ADD2_IMM = 2'b01;
   localparam logic [1:0] ADD2_0   = 2'b10;
   localparam logic [1:0] ADD2_LUI = 2'b11;

   localparam logic [1:0] ALU_OP_ADD = 2'b00;
   localparam logic [1:0] ALU_OP_SUB = 2'b01;
   localparam logic [1:0] ALU_OP_R   = 2'b10;
   localparam logic [1:0] ALU_OP_I   = 2'b11;

   typedef struct packed {
      logic       branch;
      logic       pc_sel;
      logic       lui_sel;
      logic [1:0] add2_sel;
      logic [1:0] alu_op;
      logic       mul;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       memtoreg;
   } ctrl_t;

   // All-zero bundle: ADD2_RS2 / ALU_OP_ADD, no write, no memory access.
   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_pipeline_if.sv
// rtl/ctrl_pipeline_if.sv - ID-stage inputs and stage control outputs of the control pipeline
// Purpose: bundles the IF/ID-side inputs and every pipeline control output.
// Ports:   master = control pipeline (consumes id_*/bxx_flush, drives controls)
//          slave  = datapath side (drives id_*/bxx_flush, consumes controls)
interface ctrl_pipeline_if #(
   parameter int REG_AW = 5
);
   logic [31:0]       id_instr;
   logic              id_valid;
   logic              bxx_flush;
   logic              shift_imm_sel;
   logic              s_imm_sel;
   logic              if_jalr_en;
   logic              stall_id;
   logic              mul_busy;
   logic              ex_branch;
   logic              ex_pc_sel;
   logic              ex_lui_sel;
   logic [1:0]        ex_add2_sel;
   logic [1:0]        ex_alu_op;
   logic              ex_mul;
   logic              m_mem_read;
   logic              m_mem_write;
   logic              wb_reg_write;
   logic              wb_memtoreg;
   logic [REG_AW-1:0] wb_rd;

   modport master (
      input  id_instr, id_valid, bxx_flush,
      output shift_imm_sel, s_imm_sel, if_jalr_en, stall_id, mul_busy,
             ex_branch, ex_pc_sel, ex_lui_sel, ex_add2_sel, ex_alu_op, ex_mul,
             m_mem_read, m_mem_write, wb_reg_write, wb_memtoreg, wb_rd
   );

   modport slave (
      output id_instr, id_valid, bxx_flush,
      input  shift_imm_sel, s_imm_sel, if_jalr_en, stall_id, mul_busy,
             ex_branch, ex_pc_sel, ex_lui_sel, ex_add2_sel, ex_alu_op, ex_mul,
             m_mem_read, m_mem_write, wb_reg_write, wb_memtoreg, wb_rd
   );
endinterface

// File: rtl/ctrl_pipeline_decode.sv
// rtl/ctrl_pipeline_decode.sv - combinational ID-stage instruction decoder
// Purpose: maps a 32-bit instruction to the control bundle, destination/source
//          indices, source-use flags and the ID-side immediate/JALR selects.
// Ports:   instr, valid in; ctrl, rd, rs1, rs2, rs1_used, rs2_used,
//          shift_imm, s_imm, jalr_en out
module ctrl_pipeline_decode
   import ctrl_pipeline_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int EN_MUL = 1
) (
   input  logic [31:0]       instr,
   input  logic              valid,
   output ctrl_t             ctrl,
   output logic [REG_AW-1:0] rd,
   output logic [REG_AW-1:0] rs1,
   output logic [REG_AW-1:0] rs2,
   output logic              rs1_used,
   output logic              rs2_used,
   output logic              shift_imm,
   output logic              s_imm,
   output logic              jalr_en
);
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];
   assign rs1    = instr[15 +: REG_AW];
   assign rs2    = instr[20 +: REG_AW];
   // Store/branch carry immediate bits in the rd field; only real writers expose rd.
   assign rd     = ctrl.reg_write ? instr[7 +: REG_AW] : '0;

   always_comb begin
      ctrl      = CTRL_BUBBLE;
      rs1_used  = 1'b0;
      rs2_used  = 1'b0;
      shift_imm = 1'b0;
      s_imm     = 1'b0;
      jalr_en   = 1'b0;
      if (valid) begin
         case (opcode)
            OPCODE_R: begin
               ctrl.add2_sel  = ADD2_RS2;
               ctrl.alu_op    = ALU_OP_R;
               ctrl.reg_write = 1'b1;
               ctrl.mul       = (EN_MUL != 0) && (funct7 == FUNCT7_MULDIV);
               rs1_used       = 1'b1;
               rs2_used       = 1'b1;
            end
            OPCODE_IA: begin
               ctrl.add2_sel  = ADD2_IMM;
               ctrl.alu_op    = ALU_OP_I;
               ctrl.reg_write = 1'b1;
               rs1_used       = 1'b1;
               shift_imm      = (funct3 == 3'b001) || (funct3 == 3'b101);
            end
            OPCODE_LOAD: begin
               ctrl.add2_sel  = ADD2_IMM;
               ctrl.alu_op    = ALU_OP_ADD;
               ctrl.mem_read  = 1'b1;
               ctrl.reg_write = 1'b1;
               ctrl.memtoreg  = 1'b1;
               rs1_used       = 1'b1;
            end
            OPCODE_STORE: begin
               ctrl.add2_sel  = ADD2_IMM;
               ctrl.alu_op    = ALU_OP_ADD;
               ctrl.mem_write = 1'b1;
               s_imm          = 1'b1;
               rs1_used       = 1'b1;
               rs2_used       = 1'b1;
            end
            OPCODE_B: begin
               ctrl.add2_sel  = ADD2_RS2;
               ctrl.alu_op    = ALU_OP_SUB;
               ctrl.branch    = 1'b1;
               rs1_used       = 1'b1;
               rs2_used       = 1'b1;
            end
            OPCODE_JAL, OPCODE_JALR: begin
               ctrl.add2_sel  = ADD2_0;
               ctrl.alu_op    = ALU_OP_ADD;
               ctrl.branch    = 1'b1;
               ctrl.pc_sel    = 1'b1;
               ctrl.reg_write = 1'b1;
               jalr_en        = (opcode == OPCODE_JALR);
               rs1_used       = (opcode == OPCODE_JALR);
            end
            OPCODE_LUI: begin
               ctrl.add2_sel  = ADD2_0;
               ctrl.alu_op    = ALU_OP_ADD;
               ctrl.lui_sel   = 1'b1;
               ctrl.reg_write = 1'b1;
            end
            OPCODE_AUIPC: begin
               ctrl.add2_sel  = ADD2_LUI;
               ctrl.alu_op    = ALU_OP_ADD;
               ctrl.pc_sel    = 1'b1;
               ctrl.reg_write = 1'b1;
            end
            default: ctrl = CTRL_BUBBLE;
         endcase
      end
   end
endmodule

// File: rtl/ctrl_pipeline.sv
// rtl/ctrl_pipeline.sv - RV32I(+M) control pipeline: ID decode, ID/EX, EX/MEM, MEM/WB control
// Purpose: carries the decoded control bundle through EX, MEM and WB, generates the
//          ID stall for load-use and multi-cycle MUL/DIV, and bubbles on branch flush.
// Ports:   clk, rst_n (async active-low); bus (ctrl_pipeline_if.master): id_instr,
//          id_valid, bxx_flush in; ID selects, stall_id, mul_busy, ex_*, m_*, wb_* out
module ctrl_pipeline
   import ctrl_pipeline_pkg::*;
#(
   parameter int REG_AW  = 5,
   parameter int EN_MUL  = 1,
   parameter int MUL_LAT = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   ctrl_pipeline_if.master bus
);
   localparam int              CNT_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);

   ctrl_t             dec_ctrl;
   logic [REG_AW-1:0] dec_rd, dec_rs1, dec_rs2;
   logic              dec_rs1_used, dec_rs2_used;
   logic              dec_shift_imm, dec_s_imm, dec_jalr_en;

   ctrl_t             ex_ctrl;
   logic [REG_AW-1:0] ex_rd;
   logic [CNT_W-1:0]  mul_cnt;
   logic              m_read, m_write, m_reg_write, m_memtoreg;
   logic [REG_AW-1:0] m_rd;
   logic              w_reg_write, w_memtoreg;
   logic [REG_AW-1:0] w_rd;

   logic luse;
   logic busy;

   ctrl_pipeline_decode #(.REG_AW(REG_AW), .EN_MUL(EN_MUL)) u_decode (
      .instr     (bus.id_instr),
      .valid     (bus.id_valid),
      .ctrl      (dec_ctrl),
      .rd        (dec_rd),
      .rs1       (dec_rs1),
      .rs2       (dec_rs2),
      .rs1_used  (dec_rs1_used),
      .rs2_used  (dec_rs2_used),
      .shift_imm (dec_shift_imm),
      .s_imm     (dec_s_imm),
      .jalr_en   (dec_jalr_en)
   );

   assign luse = ex_ctrl.mem_read && (ex_rd != '0) &&
                 (((ex_rd == dec_rs1) && dec_rs1_used) || ((ex_rd == dec_rs2) && dec_rs2_used));
   assign busy = ex_ctrl.mul && (mul_cnt != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_ctrl     <= CTRL_BUBBLE;
         ex_rd       <= '0;
         mul_cnt     <= '0;
         m_read      <= 1'b0;
         m_write     <= 1'b0;
         m_reg_write <= 1'b0;
         m_memtoreg  <= 1'b0;
         m_rd        <= '0;
         w_reg_write <= 1'b0;
         w_memtoreg  <= 1'b0;
         w_rd        <= '0;
      end else begin
         // Flush outranks the MUL hold; the two never coincide in practice.
         if (bus.bxx_flush) begin
            ex_ctrl <= CTRL_BUBBLE;
            ex_rd   <= '0;
            mul_cnt <= '0;
         end else if (busy) begin
            mul_cnt <= mul_cnt - CNT_W'(1);
         end else if (luse) begin
            ex_ctrl <= CTRL_BUBBLE;
            ex_rd   <= '0;
            mul_cnt <= '0;
         end else begin
            ex_ctrl <= dec_ctrl;
            ex_rd   <= dec_rd;
            mul_cnt <= dec_ctrl.mul ? MUL_LOAD : '0;
         end

         // A held MUL/DIV must not be replicated into MEM.
         if (busy) begin
            m_read      <= 1'b0;
            m_write     <= 1'b0;
            m_reg_write <= 1'b0;
            m_memtoreg  <= 1'b0;
            m_rd        <= '0;
         end else begin
            m_read      <= ex_ctrl.mem_read;
            m_write     <= ex_ctrl.mem_write;
            m_reg_write <= ex_ctrl.reg_write;
            m_memtoreg  <= ex_ctrl.memtoreg;
            m_rd        <= ex_rd;
         end

         w_reg_write <= m_reg_write;
         w_memtoreg  <= m_memtoreg;
         w_rd        <= m_rd;
      end
   end

   assign bus.shift_imm_sel = dec_shift_imm && !bus.bxx_flush;
   assign bus.s_imm_sel     = dec_s_imm     && !bus.bxx_flush;
   assign bus.if_jalr_en    = dec_jalr_en   && !bus.bxx_flush;
   assign bus.stall_id      = (luse || busy) && !bus.bxx_flush;
   assign bus.mul_busy      = busy;
   assign bus.ex_branch     = ex_ctrl.branch;
   assign bus.ex_pc_sel     = ex_ctrl.pc_sel;
   assign bus.ex_lui_sel    = ex_ctrl.lui_sel;
   assign bus.ex_add2_sel   = ex_ctrl.add2_sel;
   assign bus.ex_alu_op     = ex_ctrl.alu_op;
   assign bus.ex_mul        = ex_ctrl.mul;
   assign bus.m_mem_read    = m_read;
   assign bus.m_mem_write   = m_write;
   assign bus.wb_reg_write  = w_reg_write;
   assign bus.wb_memtoreg   = w_memtoreg;
   assign bus.wb_rd         = w_rd;
endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb/tb_ctrl_pipeline.sv - scoreboard testbench for ctrl_pipeline
module tb_ctrl_pipeline;
   localparam int F_STALL = 0,  F_BUSY = 1,  F_EXB  = 2,  F_EXPC = 3,  F_EXLUI = 4;
   localparam int F_ADD2  = 5,  F_ALU  = 6,  F_EXMUL = 7, F_MRD  = 8,  F_MWR   = 9;
   localparam int F_WBW   = 10, F_WBM  = 11, F_WBRD = 12, F_SHIMM = 13, F_SIMM = 14;
   localparam int F_JALR  = 15, F_ALL  = 16;

   localparam logic [31:0] I_ADDI  = 32'h0050_0093; // addi x1,x0,5
   localparam logic [31:0] I_SLLI  = 32'h0030_9293; // slli x5,x1,3
   localparam logic [31:0] I_JALR  = 32'h0001_00E7; // jalr x1,0(x2)
   localparam logic [31:0] I_LUI   = 32'h0000_1337; // lui  x6,1
   localparam logic [31:0] I_LW    = 32'h0000_A103; // lw   x2,0(x1)
   localparam logic [31:0] I_ADD   = 32'h0021_01B3; // add  x3,x2,x2
   localparam logic [31:0] I_LW0   = 32'h0000_A003; // lw   x0,0(x1)
   localparam logic [31:0] I_ADD0  = 32'h0000_01B3; // add  x3,x0,x0
   localparam logic [31:0] I_MUL   = 32'h0220_8233; // mul  x4,x1,x2
   localparam logic [31:0] I_MUL5  = 32'h0220_82B3; // mul  x5,x1,x2
   localparam logic [31:0] I_SW    = 32'h0020_A023; // sw   x2,0(x1)
   localparam logic [31:0] I_BEQ   = 32'h0020_8063; // beq  x1,x2,0

   typedef struct {
      int          cyc;
      int          fld;
      logic [31:0] val;
      string       tag;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cycle;
   int   n_tests;
   int   n_fail;
   exp_t sb[$];

   ctrl_pipeline_if #(.REG_AW(5)) bus ();

   ctrl_pipeline #(.REG_AW(5), .EN_MUL(1), .MUL_LAT(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cycle);
      end
   endtask

   function automatic logic [31:0] get_field(input int f);
      case (f)
         F_STALL: return {31'b0, bus.stall_id};
         F_BUSY:  return {31'b0, bus.mul_busy};
         F_EXB:   return {31'b0, bus.ex_branch};
         F_EXPC:  return {31'b0, bus.ex_pc_sel};
         F_EXLUI: return {31'b0, bus.ex_lui_sel};
         F_ADD2:  return {30'b0, bus.ex_add2_sel};
         F_ALU:   return {30'b0, bus.ex_alu_op};
         F_EXMUL: return {31'b0, bus.ex_mul};
         F_MRD:   return {31'b0, bus.m_mem_read};
         F_MWR:   return {31'b0, bus.m_mem_write};
         F_WBW:   return {31'b0, bus.wb_reg_write};
         F_WBM:   return {31'b0, bus.wb_memtoreg};
         F_WBRD:  return {27'b0, bus.wb_rd};
         F_SHIMM: return {31'b0, bus.shift_imm_sel};
         F_SIMM:  return {31'b0, bus.s_imm_sel};
         F_JALR:  return {31'b0, bus.if_jalr_en};
         F_ALL:   return {10'b0, bus.stall_id, bus.mul_busy, bus.ex_branch, bus.ex_pc_sel,
                          bus.ex_lui_sel, bus.ex_add2_sel, bus.ex_alu_op, bus.ex_mul,
                          bus.m_mem_read, bus.m_mem_write, bus.wb_reg_write, bus.wb_memtoreg,
                          bus.wb_rd, bus.shift_imm_sel, bus.s_imm_sel, bus.if_jalr_en};
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   // Expected value for field fld, dc cycles after the instruction now being driven.
   task automatic expect_at(input int dc, input int fld, input logic [31:0] val, input string tag);
      exp_t e;
      e.cyc = cycle + dc;
      e.fld = fld;
      e.val = val;
      e.tag = tag;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cycle) begin
            check_eq(sb[i].tag, get_field(sb[i].fld), sb[i].val);
            sb.delete(i);
         end
      end
   end

   task automatic issue(input logic [31:0] ins, input logic v, input logic f);
      bus.id_instr  = ins;
      bus.id_valid  = v;
      bus.bxx_flush = f;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) issue(32'h0, 1'b0, 1'b0);
   endtask

   initial begin
      n_tests       = 0;
      n_fail        = 0;
      cycle         = 0;
      rst_n         = 1'b0;
      bus.id_instr  = 32'h0;
      bus.id_valid  = 1'b0;
      bus.bxx_flush = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("reset_all_zero", get_field(F_ALL), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // ALU / jump / upper-immediate decode and 3-stage latency
      expect_at(0, F_STALL, 0, "addi_no_stall");
      expect_at(1, F_ADD2,  1, "addi_ex_add2");
      expect_at(1, F_ALU,   3, "addi_ex_alu");
      expect_at(2, F_MWR,   0, "addi_m_write");
      expect_at(3, F_WBW,   1, "addi_wb_write");
      expect_at(3, F_WBRD,  1, "addi_wb_rd");
      issue(I_ADDI, 1'b1, 1'b0);
      expect_at(0, F_SHIMM, 1, "slli_shift_imm");
      expect_at(1, F_ALU,   3, "slli_ex_alu");
      issue(I_SLLI, 1'b1, 1'b0);
      expect_at(0, F_JALR,  1, "jalr_en");
      expect_at(0, F_SHIMM, 0, "jalr_shift_imm");
      expect_at(1, F_EXB,   1, "jalr_ex_branch");
      expect_at(1, F_EXPC,  1, "jalr_ex_pc_sel");
      expect_at(1, F_ADD2,  2, "jalr_ex_add2");
      expect_at(3, F_WBRD,  1, "jalr_wb_rd");
      issue(I_JALR, 1'b1, 1'b0);
      expect_at(1, F_EXLUI, 1, "lui_ex_lui_sel");
      expect_at(1, F_ADD2,  2, "lui_ex_add2");
      expect_at(3, F_WBRD,  6, "lui_wb_rd");
      issue(I_LUI, 1'b1, 1'b0);
      idle(5);

      // Load-use: one stall cycle, EX bubble, ADD in EX two cycles after LW
      expect_at(1, F_STALL, 1, "luse_stall");
      expect_at(2, F_STALL, 0, "luse_stall_clear");
      expect_at(2, F_ALU,   0, "luse_ex_bubble");
      expect_at(2, F_MRD,   1, "lw_m_read");
      expect_at(3, F_ALU,   2, "luse_add_in_ex");
      expect_at(3, F_WBM,   1, "lw_wb_memtoreg");
      expect_at(3, F_WBRD,  2, "lw_wb_rd");
      expect_at(4, F_WBW,   0, "luse_wb_bubble");
      expect_at(5, F_WBRD,  3, "luse_add_wb_rd");
      issue(I_LW, 1'b1, 1'b0);
      issue(I_ADD, 1'b1, 1'b0);
      issue(I_ADD, 1'b1, 1'b0);
      idle(6);

      // Load to x0 never creates a hazard
      expect_at(1, F_STALL, 0, "lw_x0_no_stall");
      expect_at(2, F_ALU,   2, "x0_add_in_ex");
      expect_at(4, F_WBRD,  3, "x0_add_wb_rd");
      issue(I_LW0, 1'b1, 1'b0);
      issue(I_ADD0, 1'b1, 1'b0);
      idle(5);

      // MUL with MUL_LAT=4: three busy/stall cycles, three MEM bubbles
      for (int d = 1; d <= 3; d++) begin
         expect_at(d, F_STALL, 1, "mul_stall");
         expect_at(d, F_BUSY,  1, "mul_busy");
         expect_at(d, F_EXMUL, 1, "mul_ex_mul");
         expect_at(d + 2, F_WBW, 0, "mul_wb_bubble");
      end
      expect_at(4, F_STALL, 0, "mul_release_stall");
      expect_at(4, F_BUSY,  0, "mul_release_busy");
      expect_at(4, F_EXMUL, 1, "mul_last_ex_cycle");
      expect_at(5, F_EXMUL, 0, "mul_ex_mul_clear");
      expect_at(5, F_ADD2,  1, "mul_next_in_ex");
      expect_at(6, F_WBW,   1, "mul_wb_write");
      expect_at(6, F_WBRD,  4, "mul_wb_rd");
      expect_at(7, F_WBRD,  1, "mul_next_wb_rd");
      issue(I_MUL, 1'b1, 1'b0);
      repeat (4) issue(I_ADDI, 1'b1, 1'b0);
      idle(6);

      // Back-to-back MUL: second enters EX right after the first leaves
      expect_at(4, F_BUSY,  0, "b2b_first_release");
      expect_at(5, F_BUSY,  1, "b2b_second_busy");
      expect_at(5, F_EXMUL, 1, "b2b_second_ex_mul");
      expect_at(8, F_BUSY,  0, "b2b_second_release");
      expect_at(10, F_WBRD, 5, "b2b_second_wb_rd");
      issue(I_MUL, 1'b1, 1'b0);
      repeat (4) issue(I_MUL5, 1'b1, 1'b0);
      idle(8);

      // Taken branch flush kills the SW in ID
      expect_at(1, F_EXB, 1, "beq_ex_branch");
      expect_at(1, F_ALU, 1, "beq_ex_alu_sub");
      issue(I_BEQ, 1'b1, 1'b0);
      expect_at(0, F_SIMM,  0, "flush_s_imm");
      expect_at(0, F_STALL, 0, "flush_stall");
      expect_at(1, F_EXB,   0, "flush_ex_bubble_branch");
      expect_at(1, F_ADD2,  0, "flush_ex_bubble_add2");
      expect_at(2, F_MWR,   0, "flush_no_mem_write");
      expect_at(3, F_MWR,   0, "flush_no_mem_write_late");
      issue(I_SW, 1'b1, 1'b1);
      idle(4);
      expect_at(0, F_SIMM, 1, "sw_s_imm");
      expect_at(1, F_ADD2, 1, "sw_ex_add2");
      expect_at(2, F_MWR,  1, "sw_m_write");
      expect_at(3, F_WBW,  0, "sw_no_wb_write");
      issue(I_SW, 1'b1, 1'b0);
      idle(5);

      // Async reset in the middle of a MUL
      issue(I_MUL, 1'b1, 1'b0);
      bus.id_valid = 1'b0;
      check_eq("mid_mul_busy_before_reset", get_field(F_BUSY), 32'h1);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("mid_mul_reset_all_zero", get_field(F_ALL), 32'h0);
      @(posedge clk);
      #1;
      check_eq("mid_mul_reset_held", get_field(F_ALL), 32'h0);
      rst_n = 1'b1;
      expect_at(0, F_STALL, 0, "post_reset_no_stall");
      expect_at(1, F_BUSY,  0, "post_reset_not_busy");
      expect_at(1, F_ADD2,  1, "post_reset_ex_add2");
      expect_at(3, F_WBRD,  1, "post_reset_wb_rd");
      issue(I_ADDI, 1'b1, 1'b0);
      idle(5);

      check_eq("scoreboard_drained", sb.size(), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
